// File: rtl/t05_spi_bit_writer.sv
// Packs a serial bit stream into bytes, queues them in a small FIFO and shifts
// them out as SPI mode 0 frames with chip select held across back-to-back bytes.
//
// Pack FSM: state | meaning
//   PACK  | collecting bits MSB-first into pack_reg
//   PAD   | flush seen with partial byte; push it zero-filled
//   DRAIN | no more input; wait for FIFO and shifter to empty
//   DONE  | stream fully transmitted; done held until reset
// SPI FSM:  state | meaning
//   IDLE  | cs_n high, waiting for a queued byte
//   LOW   | sclk low half-period; mosi updated on entry
//   HIGH  | sclk high half-period; slave samples mosi on the rise
module t05_spi_bit_writer #(
  parameter int SCLK_DIV   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        flush,
  output logic        ready,
  output logic        mosi,
  output logic        sclk,
  output logic        cs_n,
  output logic [31:0] byte_count,
  output logic        done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int DW = 4;
  localparam logic [DW-1:0] DIV_LOAD = DW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {PACK, PAD, DRAIN, DONE} pack_state_t;
  typedef enum logic [1:0] {IDLE, LOW, HIGH} spi_state_t;

  pack_state_t pack_state_q, pack_state_d;
  logic [7:0]  pack_reg_q, pack_reg_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        flush_lat_q, flush_lat_d;
  logic        done_q, done_d;

  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  spi_state_t    spi_state_q, spi_state_d;
  logic [7:0]    shift_q, shift_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          mosi_q, mosi_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic [31:0]   byte_count_q, byte_count_d;

  logic       fifo_room, fifo_empty, accept, flush_req;
  logic       push, pop, start;
  logic [7:0] push_data, packed_next, head;
  logic [2:0] cnt_next, pad_shift;

  assign fifo_room  = (count_q < DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign ready      = fifo_room && (pack_state_q == PACK);
  assign accept     = bit_valid && ready;
  assign head       = fifo_mem_q[rd_ptr_q];

  always_comb begin
    pack_state_d = pack_state_q;
    pack_reg_d   = pack_reg_q;
    bit_cnt_d    = bit_cnt_q;
    flush_lat_d  = flush_lat_q;
    done_d       = done_q;
    push         = 1'b0;
    push_data    = pack_reg_q;
    packed_next  = {pack_reg_q[6:0], bit_in};
    cnt_next     = bit_cnt_q + 3'd1;
    flush_req    = flush || flush_lat_q;
    // 8 - bit_cnt, taken modulo 8, is the left-justify distance for a partial byte
    pad_shift    = 3'd0 - bit_cnt_q;
    case (pack_state_q)
      PACK: begin
        if (accept) begin
          pack_reg_d = packed_next;
          bit_cnt_d  = cnt_next;
          if (cnt_next == 3'd0) begin
            push      = 1'b1;
            push_data = packed_next;
          end
        end
        if (flush_req) begin
          if (!fifo_room) begin
            flush_lat_d = 1'b1;
          end else begin
            flush_lat_d  = 1'b0;
            pack_state_d = (bit_cnt_d == 3'd0) ? DRAIN : PAD;
          end
        end
      end
      PAD: begin
        if (fifo_room) begin
          push         = 1'b1;
          push_data    = pack_reg_q << pad_shift;
          pack_reg_d   = '0;
          bit_cnt_d    = '0;
          pack_state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && (spi_state_q == IDLE)) begin
          pack_state_d = DONE;
          done_d       = 1'b1;
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: pack_state_d = PACK;
    endcase
  end

  always_comb begin
    spi_state_d  = spi_state_q;
    shift_d      = shift_q;
    div_d        = div_q;
    bit_idx_d    = bit_idx_q;
    mosi_d       = mosi_q;
    sclk_d       = sclk_q;
    cs_n_d       = cs_n_q;
    byte_count_d = byte_count_q;
    start        = 1'b0;
    case (spi_state_q)
      IDLE: begin
        if (!fifo_empty) start = 1'b1;
      end
      LOW: begin
        if (div_q == '0) begin
          sclk_d      = 1'b1;
          div_d       = DIV_LOAD;
          spi_state_d = HIGH;
        end else begin
          div_d = div_q - DW'(1);
        end
      end
      HIGH: begin
        if (div_q != '0) begin
          div_d = div_q - DW'(1);
        end else if (bit_idx_q == 3'd7) begin
          byte_count_d = byte_count_q + 32'd1;
          if (!fifo_empty) begin
            start = 1'b1;
          end else begin
            spi_state_d = IDLE;
            cs_n_d      = 1'b1;
            sclk_d      = 1'b0;
          end
        end else begin
          bit_idx_d   = bit_idx_q + 3'd1;
          shift_d     = {shift_q[6:0], 1'b0};
          mosi_d      = shift_q[6];
          sclk_d      = 1'b0;
          div_d       = DIV_LOAD;
          spi_state_d = LOW;
        end
      end
      default: spi_state_d = IDLE;
    endcase
    // Loading the next byte is shared by IDLE and the last HIGH phase so bytes run gapless
    pop = start;
    if (start) begin
      shift_d     = head;
      mosi_d      = head[7];
      cs_n_d      = 1'b0;
      sclk_d      = 1'b0;
      div_d       = DIV_LOAD;
      bit_idx_d   = 3'd0;
      spi_state_d = LOW;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_state_q <= PACK;
      pack_reg_q   <= '0;
      bit_cnt_q    <= '0;
      flush_lat_q  <= 1'b0;
      done_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      spi_state_q  <= IDLE;
      shift_q      <= '0;
      div_q        <= '0;
      bit_idx_q    <= '0;
      mosi_q       <= 1'b0;
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      byte_count_q <= '0;
    end else begin
      pack_state_q <= pack_state_d;
      pack_reg_q   <= pack_reg_d;
      bit_cnt_q    <= bit_cnt_d;
      flush_lat_q  <= flush_lat_d;
      done_q       <= done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      spi_state_q  <= spi_state_d;
      shift_q      <= shift_d;
      div_q        <= div_d;
      bit_idx_q    <= bit_idx_d;
      mosi_q       <= mosi_d;
      sclk_q       <= sclk_d;
      cs_n_q       <= cs_n_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign mosi       = mosi_q;
  assign sclk       = sclk_q;
  assign cs_n       = cs_n_q;
  assign byte_count = byte_count_q;
  assign done       = done_q;

endmodule

// File: tb/tb_t05_spi_bit_writer.sv
// Directed bench: a bit-level packing model queues expected bytes, and an SPI
// monitor rebuilds bytes on sclk rises and compares them against the queue.
module tb_t05_spi_bit_writer;

  logic        clk, rst, bit_in, bit_valid, flush;
  logic        ready, mosi, sclk, cs_n, done;
  logic [31:0] byte_count;

  t05_spi_bit_writer #(.SCLK_DIV(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .flush(flush),
    .ready(ready), .mosi(mosi), .sclk(sclk), .cs_n(cs_n),
    .byte_count(byte_count), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_reg;
  int         model_cnt;

  logic [7:0] mon_byte, last_byte;
  int         mon_n, bytes_rx, run, last_run;
  logic       prev_sclk, prev_cs, cs_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // SPI monitor: sample on the negedge following each sclk rise
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_n = 0; bytes_rx = 0; run = 0; last_run = 0;
        prev_sclk = 1'b0; prev_cs = 1'b1; cs_seen = 1'b0; mon_byte = '0;
      end else begin
        if (sclk && !prev_sclk) begin
          mon_byte = {mon_byte[6:0], mosi};
          mon_n++;
          if (mon_n == 8) begin
            mon_n = 0;
            bytes_rx++;
            last_byte = mon_byte;
            check("byte_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("byte_data", mon_byte, exp_q.pop_front());
          end
        end
        if (!cs_n) begin
          run++;
          cs_seen = 1'b1;
        end else if (!prev_cs) begin
          last_run = run;
          run = 0;
        end
        prev_sclk = sclk;
        prev_cs   = cs_n;
      end
    end
  end

  task automatic model_bit(input logic b);
    model_reg = {model_reg[6:0], b};
    model_cnt = (model_cnt + 1) % 8;
    if (model_cnt == 0) exp_q.push_back(model_reg);
  endtask

  task automatic model_flush();
    logic [7:0] t;
    if (model_cnt != 0) begin
      t = model_reg << (8 - model_cnt);
      exp_q.push_back(t);
    end
    model_reg = '0;
    model_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bit_valid = 1'b0; flush = 1'b0; bit_in = 1'b0;
    exp_q.delete();
    model_reg = '0; model_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic with_flush);
    int guard = 0;
    bit_in = b; bit_valid = 1'b1; flush = with_flush;
    while (!ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check("send_ready_timeout", ready, 1);
    @(posedge clk);
    model_bit(b);
    if (with_flush) model_flush();
    @(negedge clk);
    bit_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    model_flush();
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k = 0;
    while (!done && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(tag, done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] pat;
  int         guard;

  initial begin
    rst = 1'b1; bit_valid = 1'b0; flush = 1'b0; bit_in = 1'b0;
    model_reg = '0; model_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_ready", ready, 1);
    check("rst_mosi", mosi, 0);
    check("rst_sclk", sclk, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_byte_count", byte_count, 0);
    check("rst_done", done, 0);

    // 0xA5 then separate flush: no pad, one 32-cycle frame
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) send_bit(pat[i], 1'b0);
    pulse_flush();
    wait_done("a5_done", 500);
    check("a5_byte_count", byte_count, 1);
    check("a5_last_byte", last_byte, 8'hA5);
    check("a5_cs_run", last_run, 32);
    check("a5_ready_in_done", ready, 0);
    bit_valid = 1'b1; bit_in = 1'b1; flush = 1'b1;
    repeat (20) @(negedge clk);
    bit_valid = 1'b0; flush = 1'b0;
    check("done_hold", done, 1);
    check("done_ignore_bits", byte_count, 1);
    check("done_cs_idle", cs_n, 1);

    // Three bits then flush: padded 0xE0
    do_reset();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    pulse_flush();
    wait_done("e0_done", 500);
    check("e0_byte_count", byte_count, 1);
    check("e0_last_byte", last_byte, 8'hE0);

    // 8th bit coincides with flush: no pad byte
    do_reset();
    pat = 8'h3C;
    for (int i = 7; i >= 1; i--) send_bit(pat[i], 1'b0);
    send_bit(pat[0], 1'b1);
    wait_done("c8_done", 500);
    repeat (40) @(negedge clk);
    check("c8_byte_count", byte_count, 1);
    check("c8_bytes_rx", bytes_rx, 1);
    check("c8_last_byte", last_byte, 8'h3C);

    // 5th bit coincides with flush: bit taken first, then padded
    do_reset();
    pat = 8'hB8;
    for (int i = 7; i >= 4; i--) send_bit(pat[i], 1'b0);
    send_bit(pat[3], 1'b1);
    wait_done("c5_done", 500);
    check("c5_byte_count", byte_count, 1);
    check("c5_last_byte", last_byte, 8'hB8);

    // 40 continuous bits: FIFO fills, flush arrives while full and must be latched
    do_reset();
    for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    check("full_ready_low", ready, 0);
    pulse_flush();
    wait_done("full_done", 1000);
    check("full_byte_count", byte_count, 5);
    check("full_bytes_rx", bytes_rx, 5);
    check("full_cs_run", last_run, 160);
    check("full_queue_empty", exp_q.size(), 0);

    // Flush on an empty stream
    do_reset();
    pulse_flush();
    @(negedge clk);
    check("empty_done", done, 1);
    check("empty_byte_count", byte_count, 0);
    repeat (10) @(negedge clk);
    check("empty_cs_never", cs_seen, 0);

    // Reset during the 4th bit of a transfer
    do_reset();
    pat = 8'h96;
    for (int i = 7; i >= 0; i--) send_bit(pat[i], 1'b0);
    guard = 0;
    while (mon_n != 3 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("mid_reached_bit3", mon_n, 3);
    repeat (2) @(negedge clk);
    check("mid_cs_active", cs_n, 0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_cs_n", cs_n, 1);
    check("mid_rst_sclk", sclk, 0);
    check("mid_rst_byte_count", byte_count, 0);
    exp_q.delete();
    model_reg = '0; model_cnt = 0;
    bit_valid = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_rst_ready", ready, 1);
    check("post_rst_cs_n", cs_n, 1);
    check("post_rst_byte_count", byte_count, 0);
    check("post_rst_no_rx", bytes_rx, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
